// File: rtl/executor_giro.sv
// Turn-manoeuvre executor: dead-time pause, timed motor drive, front-path check
// with bounded retries, and completion/failure reporting to the top controller.
module executor_giro #(
    parameter int TEMPO_PAUSA    = 4,
    parameter int TEMPO_GIRO     = 16,
    parameter int MAX_TENTATIVAS = 3,
    parameter int LARG_CONT      = 8
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Comando_Girar,
    input  logic Sensor_Direito,
    input  logic Sensor_Esquerdo,
    input  logic Sensor_Frontal,
    input  logic Saida_Erro,
    output logic Motor_Esq_Frente,
    output logic Motor_Esq_Tras,
    output logic Motor_Dir_Frente,
    output logic Motor_Dir_Tras,
    output logic Girando,
    output logic Giro_Concluido,
    output logic Giro_Falhou
);
    // state     | meaning
    // OCIOSO    | idle, waiting for a turn request
    // PAUSA     | motors off, dead-time before an attempt
    // GIRO      | driving the motors for the latched duration
    // VERIFICA  | one cycle, sample the front sensor
    // CONCLUIDO | one-cycle success report
    // FALHA     | all attempts blocked, held until request drops
    typedef enum logic [2:0] {
        OCIOSO, PAUSA, GIRO, VERIFICA, CONCLUIDO, FALHA
    } estado_t;

    localparam int LARG_TENT = $clog2(MAX_TENTATIVAS + 1);
    localparam logic [LARG_CONT-1:0] CARGA_PAUSA = LARG_CONT'(TEMPO_PAUSA - 1);
    localparam logic [LARG_CONT-1:0] CARGA_GIRO  = LARG_CONT'(TEMPO_GIRO - 1);
    localparam logic [LARG_CONT-1:0] CARGA_LONGO = LARG_CONT'(2 * TEMPO_GIRO - 1);
    localparam logic [LARG_TENT-1:0] TENT_MAX    = LARG_TENT'(MAX_TENTATIVAS);

    estado_t              estado_q, estado_d;
    logic [LARG_CONT-1:0] cont_q, cont_d;
    logic [LARG_TENT-1:0] tent_q, tent_d;
    logic                 dir_q, dir_d;      // 1 = right turn
    logic                 longo_q, longo_d;  // 1 = about-face, double duration
    logic [3:0]           motor_q, motor_d;  // {esq_frente, esq_tras, dir_frente, dir_tras}
    logic                 girando_q, girando_d;
    logic                 concl_q, concl_d;
    logic                 falhou_q, falhou_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            tent_q    <= '0;
            dir_q     <= 1'b0;
            longo_q   <= 1'b0;
            motor_q   <= '0;
            girando_q <= 1'b0;
            concl_q   <= 1'b0;
            falhou_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            tent_q    <= tent_d;
            dir_q     <= dir_d;
            longo_q   <= longo_d;
            motor_q   <= motor_d;
            girando_q <= girando_d;
            concl_q   <= concl_d;
            falhou_q  <= falhou_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cont_d   = (cont_q == '0) ? '0 : cont_q - LARG_CONT'(1);
        tent_d   = tent_q;
        dir_d    = dir_q;
        longo_d  = longo_q;

        case (estado_q)
            OCIOSO: begin
                if (Comando_Girar && !Saida_Erro) begin
                    estado_d = PAUSA;
                    cont_d   = CARGA_PAUSA;
                    tent_d   = LARG_TENT'(1);
                    dir_d    = Sensor_Esquerdo & ~Sensor_Direito;
                    longo_d  = Sensor_Esquerdo & Sensor_Direito;
                end
            end
            PAUSA: begin
                if (cont_q == '0) begin
                    estado_d = GIRO;
                    cont_d   = longo_q ? CARGA_LONGO : CARGA_GIRO;
                end
            end
            GIRO: begin
                if (cont_q == '0) begin
                    estado_d = VERIFICA;
                    cont_d   = '0;
                end
            end
            VERIFICA: begin
                cont_d = '0;
                if (!Sensor_Frontal) begin
                    estado_d = CONCLUIDO;
                end else if (tent_q < TENT_MAX) begin
                    estado_d = PAUSA;
                    cont_d   = CARGA_PAUSA;
                    tent_d   = tent_q + LARG_TENT'(1);
                end else begin
                    estado_d = FALHA;
                end
            end
            CONCLUIDO: begin
                estado_d = OCIOSO;
                cont_d   = '0;
            end
            FALHA: begin
                if (!Comando_Girar) begin
                    estado_d = OCIOSO;
                    cont_d   = '0;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cont_d   = '0;
            end
        endcase

        // System error overrides every in-flight decision, including VERIFICA
        if (Saida_Erro && (estado_q == PAUSA || estado_q == GIRO ||
                           estado_q == VERIFICA || estado_q == CONCLUIDO)) begin
            estado_d = OCIOSO;
            cont_d   = '0;
            tent_d   = '0;
        end

        // Outputs follow the next state so they change on the same edge as the state
        motor_d   = '0;
        if (estado_d == GIRO) begin
            motor_d = dir_d ? 4'b1001 : 4'b0110;
        end
        girando_d = (estado_d == PAUSA) || (estado_d == GIRO) || (estado_d == VERIFICA);
        concl_d   = (estado_d == CONCLUIDO);
        falhou_d  = (estado_d == FALHA);
    end

    assign Motor_Esq_Frente = motor_q[3];
    assign Motor_Esq_Tras   = motor_q[2];
    assign Motor_Dir_Frente = motor_q[1];
    assign Motor_Dir_Tras   = motor_q[0];
    assign Girando          = girando_q;
    assign Giro_Concluido   = concl_q;
    assign Giro_Falhou      = falhou_q;
endmodule

// File: tb/tb_executor_giro.sv
// Self-checking bench for executor_giro: table of turn scenarios, randomized
// manoeuvres against a trace-building reference model, and reset/error corner cases.
module tb_executor_giro;
    localparam int P   = 4;
    localparam int TG  = 16;
    localparam int MAX = 3;

    // expected output vector: {EsqF, EsqT, DirF, DirT, Girando, Concluido, Falhou}
    localparam logic [6:0] V_OFF  = 7'b0000000;
    localparam logic [6:0] V_GIR  = 7'b0000100;
    localparam logic [6:0] V_ESQ  = 7'b0110100;  // left turn drive
    localparam logic [6:0] V_DIR  = 7'b1001100;  // right turn drive
    localparam logic [6:0] V_CONC = 7'b0000010;
    localparam logic [6:0] V_FAL  = 7'b0000001;

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;
    logic Comando_Girar = 1'b0;
    logic Sensor_Direito = 1'b0;
    logic Sensor_Esquerdo = 1'b0;
    logic Sensor_Frontal = 1'b0;
    logic Saida_Erro = 1'b0;
    logic Motor_Esq_Frente, Motor_Esq_Tras, Motor_Dir_Frente, Motor_Dir_Tras;
    logic Girando, Giro_Concluido, Giro_Falhou;

    int errors = 0;
    int checks = 0;

    executor_giro #(
        .TEMPO_PAUSA(P), .TEMPO_GIRO(TG), .MAX_TENTATIVAS(MAX), .LARG_CONT(8)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Comando_Girar(Comando_Girar),
        .Sensor_Direito(Sensor_Direito), .Sensor_Esquerdo(Sensor_Esquerdo),
        .Sensor_Frontal(Sensor_Frontal), .Saida_Erro(Saida_Erro),
        .Motor_Esq_Frente(Motor_Esq_Frente), .Motor_Esq_Tras(Motor_Esq_Tras),
        .Motor_Dir_Frente(Motor_Dir_Frente), .Motor_Dir_Tras(Motor_Dir_Tras),
        .Girando(Girando), .Giro_Concluido(Giro_Concluido), .Giro_Falhou(Giro_Falhou)
    );

    always #5 Clock = ~Clock;

    function automatic logic [6:0] outs();
        return {Motor_Esq_Frente, Motor_Esq_Tras, Motor_Dir_Frente, Motor_Dir_Tras,
                Girando, Giro_Concluido, Giro_Falhou};
    endfunction

    task automatic check_vec(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Reference model: builds the expected per-cycle trace of a whole manoeuvre from
    // the behavioural rules (attempt loop of pause/drive/verify), then replays it.
    // nblock = number of attempts that find the front still blocked.
    task automatic run_turn(input string name, input bit sd, input bit se,
                            input int nblock, input int exp_cycle);
        logic [6:0] expv[$];
        bit         frv[$];
        bit         cmdv[$];
        int         dur, n_att, pulse_at;
        logic [6:0] drive;
        bit         pend_valid, pend_val;

        dur   = (sd && se) ? 2 * TG : TG;
        drive = (se && !sd) ? V_DIR : V_ESQ;
        n_att = (nblock < MAX) ? nblock + 1 : MAX;
        pend_valid = 1'b0;
        pend_val   = 1'b0;

        for (int a = 1; a <= n_att; a++) begin
            for (int c = 0; c < P + dur + 1; c++) begin
                if (c < P)            expv.push_back(V_GIR);
                else if (c < P + dur) expv.push_back(drive);
                else                  expv.push_back(V_GIR);
                frv.push_back(pend_valid ? pend_val : 1'($urandom_range(0, 1)));
                cmdv.push_back(1'($urandom_range(0, 1)));
                pend_valid = 1'b0;
            end
            pend_valid = 1'b1;
            pend_val   = (a <= nblock);
        end
        if (nblock < MAX) begin
            expv.push_back(V_CONC); frv.push_back(1'b0); cmdv.push_back(1'b0);
            expv.push_back(V_OFF);  frv.push_back(1'b0); cmdv.push_back(1'b0);
        end else begin
            expv.push_back(V_FAL); frv.push_back(1'b1); cmdv.push_back(1'b1);
            for (int k = 0; k < 3; k++) begin
                expv.push_back(V_FAL); frv.push_back(1'b1); cmdv.push_back(1'b1);
            end
            expv.push_back(V_OFF); frv.push_back(1'b0); cmdv.push_back(1'b0);
        end

        pulse_at = 0;
        for (int i = 0; i < expv.size(); i++) begin
            Comando_Girar  = (i == 0) ? 1'b1 : cmdv[i];
            Sensor_Direito = (i == 0) ? sd : 1'($urandom_range(0, 1));
            Sensor_Esquerdo = (i == 0) ? se : 1'($urandom_range(0, 1));
            Sensor_Frontal = frv[i];
            @(posedge Clock);
            #1;
            check_vec(name, outs(), expv[i]);
            if (Giro_Concluido && pulse_at == 0) pulse_at = i + 1;
        end
        Comando_Girar = 1'b0;
        check_int({name, " pulse cycle"}, pulse_at, exp_cycle);
    endtask

    typedef struct {
        string name;
        bit    sd;
        bit    se;
        int    nblock;
        int    exp_cycle;  // cycle of the Giro_Concluido pulse counted from the request edge, 0 = none
    } vec_t;

    initial begin
        vec_t tbl[6];
        tbl[0] = '{"right_obstacle",   1'b1, 1'b0, 0, 22};
        tbl[1] = '{"about_face",       1'b1, 1'b1, 0, 38};
        tbl[2] = '{"left_obs_retry",   1'b0, 1'b1, 1, 43};
        tbl[3] = '{"no_obstacle",      1'b0, 1'b0, 0, 22};
        tbl[4] = '{"front_blocked",    1'b0, 1'b1, 3, 0};
        tbl[5] = '{"about_face_third", 1'b1, 1'b1, 2, 112};

        #2;
        check_vec("reset_state", outs(), V_OFF);
        #10 Reset_n = 1'b1;
        @(posedge Clock); #1;
        check_vec("idle_after_reset", outs(), V_OFF);

        for (int t = 0; t < 6; t++)
            run_turn(tbl[t].name, tbl[t].sd, tbl[t].se, tbl[t].nblock, tbl[t].exp_cycle);

        // Saida_Erro at the 5th drive cycle aborts without a completion pulse
        for (int i = 0; i < 14; i++) begin
            Comando_Girar   = (i == 0);
            Sensor_Direito  = 1'b0;
            Sensor_Esquerdo = 1'b0;
            Saida_Erro      = (i == 9);
            @(posedge Clock); #1;
            check_vec("error_abort", outs(), (i < P) ? V_GIR : (i < 9) ? V_ESQ : V_OFF);
        end
        Saida_Erro = 1'b0;

        // Saida_Erro blocks a start from idle
        Comando_Girar = 1'b1;
        Saida_Erro    = 1'b1;
        @(posedge Clock); #1;
        check_vec("error_blocks_start", outs(), V_OFF);
        Comando_Girar = 1'b0;
        Saida_Erro    = 1'b0;

        // Saida_Erro wins over a VERIFICA decision on the same edge
        for (int i = 0; i < P + TG + 3; i++) begin
            Comando_Girar  = (i == 0);
            Sensor_Direito = (i == 0);
            Sensor_Frontal = 1'b0;
            Saida_Erro     = (i == P + TG + 1);
            @(posedge Clock); #1;
            check_vec("error_at_verifica", outs(),
                      (i < P) ? V_GIR : (i < P + TG) ? V_ESQ : (i == P + TG) ? V_GIR : V_OFF);
        end
        Saida_Erro = 1'b0;

        // Asynchronous reset mid-drive
        Comando_Girar  = 1'b1;
        Sensor_Direito = 1'b1;
        @(posedge Clock); #1;
        Comando_Girar = 1'b0;
        repeat (8) @(posedge Clock);
        #1;
        check_vec("pre_reset_drive", outs(), V_ESQ);
        #2 Reset_n = 1'b0;
        #1;
        check_vec("async_reset", outs(), V_OFF);
        @(posedge Clock); #1;
        check_vec("held_in_reset", outs(), V_OFF);
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        check_vec("idle_after_release", outs(), V_OFF);

        // Randomized manoeuvres against the reference model
        for (int r = 0; r < 10; r++) begin
            bit sd, se;
            int nb, dur, expc;
            sd  = 1'($urandom_range(0, 1));
            se  = 1'($urandom_range(0, 1));
            nb  = $urandom_range(0, MAX);
            dur = (sd && se) ? 2 * TG : TG;
            expc = (nb < MAX) ? (nb + 1) * (P + dur + 1) + 1 : 0;
            run_turn("random_turn", sd, se, nb, expc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
